// File: rtl/noc_pkg.sv
// Flit layout shared by the PE network interface and its FIFOs.
// Field offsets describe the 42-bit flit, MSB first.
package noc_pkg;

  localparam int FLIT_COORD_W   = 4;
  localparam int FLIT_W         = 42;
  localparam int FLIT_PAYLOAD_W = FLIT_W - 4 * FLIT_COORD_W;

  localparam int DST_X_MSB = 41;
  localparam int DST_X_LSB = 38;
  localparam int DST_Y_MSB = 37;
  localparam int DST_Y_LSB = 34;
  localparam int SRC_X_MSB = 33;
  localparam int SRC_X_LSB = 30;
  localparam int SRC_Y_MSB = 29;
  localparam int SRC_Y_LSB = 26;
  localparam int PLD_MSB   = 25;
  localparam int PLD_LSB   = 0;

  typedef struct packed {
    logic [FLIT_COORD_W-1:0]   dst_x;
    logic [FLIT_COORD_W-1:0]   dst_y;
    logic [FLIT_COORD_W-1:0]   src_x;
    logic [FLIT_COORD_W-1:0]   src_y;
    logic [FLIT_PAYLOAD_W-1:0] payload;
  } flit_t;

  function automatic logic [FLIT_W-1:0] pack_flit(
    input logic [FLIT_COORD_W-1:0]   dst_x,
    input logic [FLIT_COORD_W-1:0]   dst_y,
    input logic [FLIT_COORD_W-1:0]   src_x,
    input logic [FLIT_COORD_W-1:0]   src_y,
    input logic [FLIT_PAYLOAD_W-1:0] payload
  );
    flit_t f;
    f.dst_x   = dst_x;
    f.dst_y   = dst_y;
    f.src_x   = src_x;
    f.src_y   = src_y;
    f.payload = payload;
    return f;
  endfunction

  function automatic flit_t unpack_flit(input logic [FLIT_W-1:0] data);
    flit_t f;
    f.dst_x   = data[DST_X_MSB:DST_X_LSB];
    f.dst_y   = data[DST_Y_MSB:DST_Y_LSB];
    f.src_x   = data[SRC_X_MSB:SRC_X_LSB];
    f.src_y   = data[SRC_Y_MSB:SRC_Y_LSB];
    f.payload = data[PLD_MSB:PLD_LSB];
    return f;
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock FIFO with an extra pointer wrap bit to separate full from empty.
// The head entry is presented combinationally; storage is cleared on reset.
module noc_sync_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/noc_pe_interface.sv
// Network interface between a neuron PE and its mesh switch PE port.
// TX packs events into flits; RX keeps flits addressed here and drops the rest.
module noc_pe_interface
  import noc_pkg::*;
#(
  parameter int MY_X       = 0,
  parameter int MY_Y       = 0,
  parameter int COORD_W    = 4,
  parameter int DATA_WIDTH = 42,
  parameter int FIFO_DEPTH = 4,
  localparam int PAYLOAD_W = DATA_WIDTH - 4 * COORD_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  input  logic [COORD_W-1:0]    i_tx_dst_x,
  input  logic [COORD_W-1:0]    i_tx_dst_y,
  input  logic [PAYLOAD_W-1:0]  i_tx_payload,
  output logic                  o_sw_valid,
  input  logic                  i_sw_ready,
  output logic [DATA_WIDTH-1:0] o_sw_data,
  input  logic                  i_sw_valid,
  output logic                  o_sw_ready,
  input  logic [DATA_WIDTH-1:0] i_sw_data,
  output logic                  o_rx_valid,
  input  logic                  i_rx_ready,
  output logic [COORD_W-1:0]    o_rx_src_x,
  output logic [COORD_W-1:0]    o_rx_src_y,
  output logic [PAYLOAD_W-1:0]  o_rx_payload,
  output logic [15:0]           o_tx_count,
  output logic [15:0]           o_rx_count,
  output logic [7:0]            o_drop_count
);

  localparam logic [COORD_W-1:0] MY_X_C = COORD_W'(MY_X);
  localparam logic [COORD_W-1:0] MY_Y_C = COORD_W'(MY_Y);
  // RX entries carry only what the PE sees: source coordinate and payload.
  localparam int RX_W = 2 * COORD_W + PAYLOAD_W;

  logic                  w_tx_full;
  logic                  w_tx_empty;
  logic                  w_tx_push;
  logic                  w_tx_pop;
  logic [DATA_WIDTH-1:0] w_tx_flit;
  logic                  w_rx_full;
  logic                  w_rx_empty;
  logic                  w_sw_accept;
  logic                  w_dst_match;
  logic                  w_rx_push;
  logic                  w_rx_pop;
  logic                  w_drop;
  flit_t                 w_rx_in;
  logic [RX_W-1:0]       w_rx_entry;
  logic [RX_W-1:0]       w_rx_head;
  logic [15:0]           r_tx_count;
  logic [15:0]           r_rx_count;
  logic [7:0]            r_drop_count;

  assign w_tx_flit  = pack_flit(i_tx_dst_x, i_tx_dst_y, MY_X_C, MY_Y_C, i_tx_payload);
  assign o_tx_ready = !w_tx_full;
  assign o_sw_valid = !w_tx_empty;
  assign w_tx_push  = i_tx_valid && o_tx_ready;
  assign w_tx_pop   = o_sw_valid && i_sw_ready;

  noc_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_tx_push),
    .i_data  (w_tx_flit),
    .i_pop   (w_tx_pop),
    .o_data  (o_sw_data),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  // Every accepted flit is consumed; only those addressed here are buffered.
  assign w_rx_in     = unpack_flit(i_sw_data);
  assign o_sw_ready  = !w_rx_full;
  assign w_sw_accept = i_sw_valid && o_sw_ready;
  assign w_dst_match = (w_rx_in.dst_x == MY_X_C) && (w_rx_in.dst_y == MY_Y_C);
  assign w_rx_push   = w_sw_accept && w_dst_match;
  assign w_drop      = w_sw_accept && !w_dst_match;
  assign w_rx_entry  = {w_rx_in.src_x, w_rx_in.src_y, w_rx_in.payload};
  assign o_rx_valid  = !w_rx_empty;
  assign w_rx_pop    = o_rx_valid && i_rx_ready;

  noc_sync_fifo #(.WIDTH(RX_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_rx_push),
    .i_data  (w_rx_entry),
    .i_pop   (w_rx_pop),
    .o_data  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  assign o_rx_src_x   = w_rx_head[RX_W-1 -: COORD_W];
  assign o_rx_src_y   = w_rx_head[PAYLOAD_W +: COORD_W];
  assign o_rx_payload = w_rx_head[PAYLOAD_W-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_count   <= '0;
      r_rx_count   <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_tx_pop) r_tx_count <= r_tx_count + 16'd1;
      if (w_rx_pop) r_rx_count <= r_rx_count + 16'd1;
      if (w_drop && (r_drop_count != 8'hFF)) r_drop_count <= r_drop_count + 8'd1;
    end
  end

  assign o_tx_count   = r_tx_count;
  assign o_rx_count   = r_rx_count;
  assign o_drop_count = r_drop_count;

endmodule

// File: doc/noc_pe_interface.md
Name: noc_pe_interface

Overview:
Network interface between one neuron PE and the PE port of its mesh switch.
- TX path: packs PE events (destination coordinate plus payload) into 42-bit flits, buffers them, and drives them into the switch PE input with a valid/ready handshake.
- RX path: accepts flits from the switch PE output, checks the destination against its own coordinate, and presents the source and payload to the PE.
- One instance sits beside every switch in the X×Y mesh.

Parameters:
- MY_X, 0, this node's column coordinate.
- MY_Y, 0, this node's row coordinate.
- COORD_W, 4, width of each coordinate field.
- DATA_WIDTH, 42, flit width (matches switch data ports [41:0]).
- FIFO_DEPTH, 4, entries per TX and RX FIFO; must be a power of 2, ≥2.
- PAYLOAD_W (localparam), DATA_WIDTH-4*COORD_W = 26, payload field width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_tx_valid  in  1  PE has an event to send
- o_tx_ready  out  1  interface accepts the event
- i_tx_dst_x  in  COORD_W  destination column
- i_tx_dst_y  in  COORD_W  destination row
- i_tx_payload  in  PAYLOAD_W  event payload
- o_sw_valid  out  1  flit valid toward switch PE input
- i_sw_ready  in  1  switch accepts flit
- o_sw_data  out  DATA_WIDTH  outgoing flit
- i_sw_valid  in  1  flit valid from switch PE output
- o_sw_ready  out  1  interface accepts flit
- i_sw_data  in  DATA_WIDTH  incoming flit
- o_rx_valid  out  1  delivered event valid to PE
- i_rx_ready  in  1  PE accepts event
- o_rx_src_x  out  COORD_W  source column of delivered event
- o_rx_src_y  out  COORD_W  source row of delivered event
- o_rx_payload  out  PAYLOAD_W  delivered payload
- o_tx_count  out  16  flits handed to switch, wraps
- o_rx_count  out  16  events delivered to PE, wraps
- o_drop_count  out  8  misrouted flits dropped, saturates at 255

Behaviour:
Flit format (MSB first):
- [41:38] dst_x, [37:34] dst_y, [33:30] src_x, [29:26] src_y, [25:0] payload.
- Src fields are always MY_X/MY_Y.

Reset (i_rst_n low, asynchronous):
- Both FIFOs emptied (pointers cleared, storage zeroed).
- Counters cleared.
- o_sw_valid = o_rx_valid = 0 immediately; all data outputs 0.
- o_tx_ready = o_sw_ready = 1 (FIFOs empty).

TX path:
- Push on i_tx_valid & o_tx_ready; o_tx_ready = !tx_full.
- o_sw_valid = !tx_empty; o_sw_data = TX FIFO head.
- Pop on o_sw_valid & i_sw_ready.
- Latency: event accepted at edge N → o_sw_valid at N+1. No same-cycle bypass.
- Full: o_tx_ready is 0 even if a pop occurs that cycle. Ready depends on the full flag only.
- Empty: push and pop in the same cycle is impossible, because o_sw_valid = 0.
- Push with pop when not full: occupancy unchanged.
- Pointers wrap modulo FIFO_DEPTH. An extra wrap bit distinguishes full from empty.
- Self-addressed events (dst == MY) are still sent to the switch.
- o_sw_data and o_sw_valid are held stable while o_sw_valid & !i_sw_ready.

RX path:
- o_sw_ready = !rx_full.
- On i_sw_valid & o_sw_ready, the flit is always consumed:
  - dst == (MY_X, MY_Y): written to the RX FIFO.
  - Otherwise: discarded, and o_drop_count += 1 (saturating at 255).
- o_rx_valid = !rx_empty; src/payload fields come from the RX FIFO head.
- Pop on o_rx_valid & i_rx_ready.
- Latency: flit accepted at N → o_rx_valid at N+1.
- Full/stability rules are identical to TX.

Counters:
- o_tx_count increments on the switch handshake.
- o_rx_count increments on the PE handshake.
- Both wrap at 2^16.

Reset mid-operation: buffered flits are lost. Nothing is emitted after release until a new push.

Decomposition:
- Package noc_pkg:
  - constants: COORD_W, DATA_WIDTH, PAYLOAD_W, field MSB/LSB offsets.
  - typedef flit_t: packed struct dst_x, dst_y, src_x, src_y, payload.
  - functions pack_flit() / unpack_flit().
- Sub-module noc_sync_fifo (params WIDTH, DEPTH): async active-low reset, push/pop, full/empty flags. Instantiated twice, once for TX and once for RX.

Test Plan:
1. Reset: hold i_rst_n low 3 cycles, release → o_tx_ready=1, o_sw_ready=1, o_sw_valid=0, o_rx_valid=0, all counters 0.
2. Single TX: MY=(1,0), i_sw_ready=1, push dst (0,1) payload 26'h0ABCDEF at edge N → at N+1, o_sw_valid=1 and o_sw_data={4'h0,4'h1,4'h1,4'h0,26'h0ABCDEF}; at N+2, o_tx_count=1.
3. TX backpressure: i_sw_ready=0, offer 5 events with payloads 1..5 → first 4 accepted, o_tx_ready=0 while the 5th waits. Raise i_sw_ready → payloads 1..5 emitted in order, o_sw_data stable while stalled, o_tx_count=5.
4. RX match/drop: MY=(1,0); inject flit dst (1,0) src (3,2) payload 7 → o_rx_valid=1, o_rx_src_x=3, o_rx_src_y=2, o_rx_payload=7. Then inject dst (2,2) → consumed, o_rx_valid stays 0 after the first event is popped, o_drop_count=1.
5. RX full: i_rx_ready=0, inject 5 matching flits → o_sw_ready=0 after the 4th. Raise i_rx_ready → 5 events delivered in order, o_rx_count=5. Inject 300 misrouted flits → o_drop_count=255.
6. Reset mid-operation: 3 events in TX FIFO with i_sw_ready=0, pulse i_rst_n low between edges → o_sw_valid drops to 0 without a clock edge. After release with i_sw_ready=1 → no flit emitted, o_tx_count=0.
